// File: rtl/kbd_pkg.sv
// Shared constants for the BBC Micro keyboard matrix emulation: matrix geometry,
// key-code field layout and a few named key codes.
package kbd_pkg;

    localparam int KBD_ROWS = 8;
    localparam int KBD_COLS = 10;

    localparam int ROW_MSB = 6;
    localparam int ROW_LSB = 4;
    localparam int COL_MSB = 3;
    localparam int COL_LSB = 0;

    localparam logic [6:0] KEY_SHIFT  = 7'h00;
    localparam logic [6:0] KEY_CTRL   = 7'h01;
    localparam logic [6:0] KEY_A      = 7'h41;
    localparam logic [6:0] KEY_SPACE  = 7'h62;
    localparam logic [6:0] KEY_RETURN = 7'h49;
    localparam logic [6:0] KEY_ESCAPE = 7'h70;

endpackage

// File: rtl/kbd_scan_counter.sv
// 4-bit keyboard column counter (autoscan increment or CPU load) with the
// registered any-key (CA2) stage sampling the column presented before each enable.
module kbd_scan_counter
    import kbd_pkg::*;
(
    input  logic        clk,
    input  logic        nRESET,
    input  logic        clk_en,
    input  logic        nKBEN,
    input  logic [3:0]  load_col,
    input  logic [15:0] col_any,
    output logic [3:0]  column,
    output logic        ca2
);

    logic [3:0] column_reg;
    logic [3:0] column_next;
    logic       ca2_reg;

    always_comb begin
        column_next = load_col;
        if (nKBEN) begin
            column_next = column_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            column_reg <= 4'd0;
            ca2_reg    <= 1'b0;
        end else if (clk_en) begin
            // CA2 reflects the column being scanned up to this edge, so it lags COLUMN
            ca2_reg    <= col_any[column_reg];
            column_reg <= column_next;
        end
    end

    assign column = column_reg;
    assign ca2    = ca2_reg;

endmodule

// File: rtl/bbc_keyboard_matrix.sv
// BBC Micro keyboard matrix: host-driven key state plus DIP links, manual query
// output to VIA PA7 and autoscan any-key interrupt on CA2.
module bbc_keyboard_matrix
    import kbd_pkg::*;
#(
    parameter logic [7:0] DIP      = 8'h00,
    parameter int         NUM_COLS = KBD_COLS
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       key_valid,
    input  logic       key_make,
    input  logic [6:0] key_code,
    input  logic       key_clear,
    input  logic       nKBEN,
    input  logic [6:0] PA_SEL,
    output logic       PA7,
    output logic       CA2,
    output logic [3:0] COLUMN
);

    logic [2:0]                 key_row;
    logic [3:0]                 key_col;
    logic [15:0][KBD_ROWS-1:0]  eff_matrix;
    logic [15:0]                col_any;

    assign key_row = key_code[ROW_MSB:ROW_LSB];
    assign key_col = key_code[COL_MSB:COL_LSB];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_col
            if (gi < NUM_COLS) begin : g_live
                // Row 0 of columns 2-9 is wired to the startup links, not the host
                localparam bit READ_ONLY = (gi >= 2) && (gi <= 9);
                logic [KBD_ROWS-1:0] host_reg;
                logic                dip_bit;

                if (READ_ONLY) begin : g_dip
                    assign dip_bit = DIP[gi-2];
                end else begin : g_nodip
                    assign dip_bit = 1'b0;
                end

                always_ff @(posedge clk) begin
                    if (!nRESET) begin
                        host_reg <= '0;
                    end else if (key_clear) begin
                        host_reg <= '0;
                    end else if (key_valid && key_col == 4'(gi)
                                 && !(READ_ONLY && key_row == 3'd0)) begin
                        host_reg[key_row] <= key_make;
                    end
                end

                assign eff_matrix[gi] = host_reg | {{(KBD_ROWS-1){1'b0}}, dip_bit};
            end else begin : g_empty
                assign eff_matrix[gi] = '0;
            end

            assign col_any[gi] = |eff_matrix[gi][KBD_ROWS-1:1];
        end
    endgenerate

    assign PA7 = !nKBEN && eff_matrix[PA_SEL[3:0]][PA_SEL[6:4]];

    kbd_scan_counter u_scan (
        .clk      (clk),
        .nRESET   (nRESET),
        .clk_en   (clk_en),
        .nKBEN    (nKBEN),
        .load_col (PA_SEL[3:0]),
        .col_any  (col_any),
        .column   (COLUMN),
        .ca2      (CA2)
    );

endmodule

// File: tb/tb_bbc_keyboard_matrix.sv
// Directed bench for bbc_keyboard_matrix: expectations queued as stimulus is
// driven, then popped and checked when the outputs are sampled.
module tb_bbc_keyboard_matrix;
    import kbd_pkg::*;

    logic       clk = 1'b0;
    logic       nRESET;
    logic       clk_en;
    logic       key_valid;
    logic       key_make;
    logic [6:0] key_code;
    logic       key_clear;
    logic       nKBEN;
    logic [6:0] PA_SEL;
    logic       PA7;
    logic       CA2;
    logic [3:0] COLUMN;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        int         sel;   // 0 = PA7, 1 = CA2, 2 = COLUMN
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];

    bbc_keyboard_matrix #(.DIP(8'b0000_0101), .NUM_COLS(10)) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .clk_en    (clk_en),
        .key_valid (key_valid),
        .key_make  (key_make),
        .key_code  (key_code),
        .key_clear (key_clear),
        .nKBEN     (nKBEN),
        .PA_SEL    (PA_SEL),
        .PA7       (PA7),
        .CA2       (CA2),
        .COLUMN    (COLUMN)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [3:0] val);
        sb.push_back('{tag, sel, val});
    endtask

    task automatic check_now();
        exp_t       e;
        logic [3:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = {3'b000, PA7};
                1:       obs = {3'b000, CA2};
                default: obs = COLUMN;
            endcase
            checks++;
            assert (obs === e.val)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic key_event(input logic make, input logic [6:0] code);
        key_valid = 1'b1;
        key_make  = make;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic en_pulse();
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
    endtask

    task automatic query(input string tag, input logic [6:0] sel, input logic exp);
        PA_SEL = sel;
        expect_out(tag, 0, {3'b000, exp});
        check_now();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0; clk_en = 1'b0; key_valid = 1'b0; key_make = 1'b0;
        key_code = 7'h00; key_clear = 1'b0; nKBEN = 1'b0; PA_SEL = KEY_A;
        tick();
        tick();
        nRESET = 1'b1;
        expect_out("reset_pa7", 0, 4'd0);
        expect_out("reset_ca2", 1, 4'd0);
        expect_out("reset_col", 2, 4'd0);
        check_now();

        // Make A: PA7 responds immediately; CA2 once COLUMN=1 has been scanned
        key_event(1'b1, KEY_A);
        expect_out("make_a_pa7", 0, 4'd1);
        check_now();
        en_pulse();
        expect_out("manual_load_col", 2, 4'd1);
        expect_out("ca2_col0", 1, 4'd0);
        check_now();
        en_pulse();
        expect_out("ca2_a", 1, 4'd1);
        check_now();

        // SHIFT is row 0: visible to PA7, never to CA2
        key_event(1'b1, KEY_SHIFT);
        PA_SEL = KEY_SHIFT;
        expect_out("shift_pa7", 0, 4'd1);
        check_now();
        en_pulse();
        en_pulse();
        expect_out("shift_ca2", 1, 4'd0);
        check_now();

        // DIP links on row 0 columns 2 and 4, read-only
        query("dip_c2", 7'h02, 1'b1);
        query("dip_c3", 7'h03, 1'b0);
        query("dip_c4", 7'h04, 1'b1);
        key_event(1'b0, 7'h02);
        query("dip_c2_break", 7'h02, 1'b1);
        key_event(1'b1, 7'h03);
        query("dip_c3_make", 7'h03, 1'b0);

        // Autoscan with SPACE (column 2) held alone
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        query("clear_a", KEY_A, 1'b0);
        key_event(1'b1, KEY_SPACE);
        PA_SEL = 7'h00;
        en_pulse();
        en_pulse();
        expect_out("pre_scan_col", 2, 4'd0);
        check_now();
        nKBEN = 1'b1;
        PA_SEL = KEY_SPACE;
        for (int c = 0; c < 17; c++) begin
            en_pulse();
            expect_out($sformatf("scan_col_%0d", c), 2, 4'((c + 1) % 16));
            expect_out($sformatf("scan_ca2_%0d", c), 1, {3'b000, (c % 16) == 2});
            expect_out($sformatf("scan_pa7_%0d", c), 0, 4'd0);
            check_now();
        end

        // Back to manual: event with key_clear is dropped; column 12 ignored
        nKBEN = 1'b0;
        key_valid = 1'b1; key_make = 1'b1; key_code = KEY_A; key_clear = 1'b1;
        tick();
        key_valid = 1'b0; key_clear = 1'b0;
        query("clear_wins_a", KEY_A, 1'b0);
        query("clear_space", KEY_SPACE, 1'b0);
        key_event(1'b1, 7'h4C);
        query("col12_pa7", 7'h4C, 1'b0);

        // Event coincident with clk_en: CA2 sees the pre-event matrix
        PA_SEL = KEY_A;
        en_pulse();
        en_pulse();
        expect_out("col1_loaded", 2, 4'd1);
        expect_out("col1_empty_ca2", 1, 4'd0);
        check_now();
        key_valid = 1'b1; key_make = 1'b1; key_code = KEY_A; clk_en = 1'b1;
        tick();
        key_valid = 1'b0; clk_en = 1'b0;
        expect_out("same_cycle_ca2", 1, 4'd0);
        expect_out("same_cycle_pa7", 0, 4'd1);
        check_now();
        en_pulse();
        expect_out("next_en_ca2", 1, 4'd1);
        check_now();

        // Repeated make then a single break releases the key
        key_event(1'b1, KEY_A);
        key_event(1'b0, KEY_A);
        query("break_a", KEY_A, 1'b0);
        key_event(1'b0, KEY_A);
        query("break_again", KEY_A, 1'b0);
        key_event(1'b1, KEY_RETURN);
        query("return_pa7", KEY_RETURN, 1'b1);

        // Reset in the middle of autoscan with keys held
        key_event(1'b1, KEY_A);
        key_event(1'b1, KEY_ESCAPE);
        nKBEN = 1'b1;
        en_pulse(); en_pulse(); en_pulse();
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        expect_out("rst2_col", 2, 4'd0);
        expect_out("rst2_ca2", 1, 4'd0);
        check_now();
        nKBEN = 1'b0;
        query("rst2_a", KEY_A, 1'b0);
        query("rst2_esc", KEY_ESCAPE, 1'b0);
        query("rst2_ret", KEY_RETURN, 1'b0);
        query("rst2_dip", 7'h04, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
